m72_pic: RTL and testbench
==========================

M72_PIC -- requirements
Module: m72_pic

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of request channels, legal range 1..8.
REQ-002 SHALL have parameter VEC_BASE_RST, default 8'h20, reset value of the vector base register.
REQ-003 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cs  input  1  register access strobe, one access per clock while high.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; qualified by cs.
REQ-007 SHALL have port addr  input  2  register select: 0 = IMR, 1 = base (write) / IRR (read), 2 = EOI (write) / ISR (read), 3 = reserved.
REQ-008 SHALL have port din  input  8  write data.
REQ-009 SHALL have port dout  output  8  read data, combinational from addr; unused high bits 0; addr 3 reads 8'hFF.
REQ-010 SHALL have port irq_in  input  NUM_IRQ  interrupt sources, rising-edge sensitive.
REQ-011 SHALL have port intr  output  1  registered interrupt request to CPU.
REQ-012 SHALL have port inta  input  1  CPU acknowledge level (wb_tgc_o style).
REQ-013 SHALL have port vector  output  8  registered vector, valid while vec_valid high.
REQ-014 SHALL have port vec_valid  output  1  high in ACK state.

Function
REQ-015 SHALL register irq_in each clock; prev=0, now=1 on channel n sets IRR[n] next clock.
REQ-016 SHALL compute pending = IRR & ~IMR; winner = lowest-index pending bit (channel 0 highest priority).
REQ-017 SHALL assert intr one clock after a pending bit exists whose index is lower than the lowest set ISR bit (ISR empty = any pending qualifies); deassert one clock after condition clears.
REQ-018 SHALL implement FSM IDLE -> ACK on inta rising edge (registered inta 0, inta 1); ACK -> IDLE when inta low; inta held high in ACK = stay.
REQ-019 On IDLE->ACK with a winner n: vector <= base + n, ISR[n] <= 1, IRR[n] <= 0, same clock.
REQ-020 On IDLE->ACK with no qualifying pending bit (spurious): vector <= base + 7, IRR/ISR unchanged.
REQ-021 Edge on channel n in same clock as its acknowledge SHALL leave IRR[n] = 1 (new request wins).
REQ-022 Write addr 0 SHALL load IMR[NUM_IRQ-1:0]; masking does not clear IRR.
REQ-023 Write addr 1 SHALL load base <= {din[7:3], 3'b000}.
REQ-024 Write addr 2 (any data) SHALL clear lowest-index set ISR bit; ISR empty = no effect.
REQ-025 Register write concurrent with IDLE->ACK SHALL take effect after the acknowledge decision (decision uses pre-write IMR/ISR).
REQ-026 base + n arithmetic SHALL be 8-bit, wrapping modulo 256 (base low 3 bits always 0, so no carry).

Reset
REQ-027 On reset_n low at a clock edge: IRR=0, ISR=0, IMR=all ones (masked), base=VEC_BASE_RST & 8'hF8, FSM=IDLE, intr=0, vector=0, vec_valid=0, irq_in/inta history=0.
REQ-028 Reset during ACK SHALL abort the cycle; a source held high through reset SHALL NOT register an edge until it falls and rises again.

Configuration
REQ-029 With M72_PIC_AUTO_EOI_EN defined: acknowledge does not set ISR, ISR reads 0, EOI writes ignored, intr qualifies on pending alone; without it: fully nested ISR behaviour of REQ-017/019/024.

Verification
REQ-030 Reset, IMR=8'h00, base=8'h20, pulse irq_in[3] -> intr=1 two clocks after edge; inta rise -> vector=8'h23, vec_valid=1, ISR=8'h08, IRR=0.
REQ-031 Edges on channels 5 and 1 same clock, two ack cycles with EOI between -> vectors 8'h21 then 8'h25.
REQ-032 ISR[2] set, edge on channel 4 -> intr stays 0; edge on channel 0 -> intr=1, ack vector 8'h20; EOI clears ISR[0] then ISR[2].
REQ-033 IMR=8'hFF, edge on channel 2, inta rise -> vector=8'h27 spurious, IRR[2]=1 retained; IMR=0 -> intr=1.
REQ-034 Channel 6 edge coincident with its acknowledge -> IRR[6]=1 after ack, second intr follows EOI.
REQ-035 Build with M72_PIC_AUTO_EOI_EN, channel 3 edges twice with acks, no EOI -> two vectors 8'h23, ISR reads 0.

Source files
------------

// File: rtl/m72_pic.sv
// Single-controller programmable interrupt controller: edge-triggered IRR, IMR mask, fully nested ISR.
// Define M72_PIC_AUTO_EOI_EN to build the auto-EOI variant (ISR never set, EOI writes ignored).
module m72_pic #(
    parameter int         NUM_IRQ      = 8,
    parameter logic [7:0] VEC_BASE_RST = 8'h20
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cs,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               intr,
    input  logic               inta,
    output logic [7:0]         vector,
    output logic               vec_valid
);

    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    state_t             state_reg, state_next;
    logic [NUM_IRQ-1:0] irq_prev_reg, irq_arm_reg;
    logic [NUM_IRQ-1:0] irr_reg, irr_next;
    logic [NUM_IRQ-1:0] isr_reg, isr_next;
    logic [NUM_IRQ-1:0] imr_reg;
    logic [7:0]         base_reg;
    logic [7:0]         vector_reg, vector_next;
    logic               inta_prev_reg, inta_arm_reg;
    logic               intr_reg;

    logic [NUM_IRQ-1:0] irq_edge, pending, isr_low, below, qual, win_onehot;
    logic [2:0]         win;
    logic               inta_rise, ack_fire, eoi;
    logic [7:0]         imr_pad, irr_pad, isr_pad;

    // Arm bits block edges from sources that were already high when reset was applied.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_edge
            assign irq_edge[gi] = irq_in[gi] & ~irq_prev_reg[gi] & irq_arm_reg[gi];
        end
    endgenerate

    assign inta_rise = inta & ~inta_prev_reg & inta_arm_reg;
    assign pending   = irr_reg & ~imr_reg;
    assign isr_low   = isr_reg & (~isr_reg + NUM_IRQ'(1));
`ifdef M72_PIC_AUTO_EOI_EN
    assign below     = '1;
`else
    // Bits strictly below the highest-priority in-service level; all ones when ISR is empty.
    assign below     = isr_low - NUM_IRQ'(1);
`endif
    assign qual       = pending & below;
    assign win_onehot = qual & (~qual + NUM_IRQ'(1));
    assign eoi        = cs && we && (addr == 2'd2);

    always_comb begin
        win = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (qual[i]) win = 3'(i);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (inta_rise) state_next = ST_ACK;
            ST_ACK:  if (!inta)     state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_fire  = (state_reg == ST_IDLE) && inta_rise;
        vec_valid = (state_reg == ST_ACK);
    end

    always_comb begin
        irr_next = irr_reg;
        if (ack_fire) irr_next = irr_next & ~win_onehot;
        irr_next = irr_next | irq_edge;

`ifdef M72_PIC_AUTO_EOI_EN
        isr_next = '0;
`else
        isr_next = isr_reg;
        if (ack_fire) isr_next = isr_next | win_onehot;
        if (eoi)      isr_next = isr_next & ~(isr_next & (~isr_next + NUM_IRQ'(1)));
`endif

        vector_next = vector_reg;
        if (ack_fire) vector_next = base_reg + ((|qual) ? {5'b0, win} : 8'd7);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            irq_prev_reg  <= '0;
            irq_arm_reg   <= ~irq_in;
            inta_prev_reg <= 1'b0;
            inta_arm_reg  <= ~inta;
            irr_reg       <= '0;
            isr_reg       <= '0;
            imr_reg       <= '1;
            base_reg      <= VEC_BASE_RST & 8'hF8;
            vector_reg    <= 8'h00;
            intr_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            irq_prev_reg  <= irq_in;
            irq_arm_reg   <= irq_arm_reg | ~irq_in;
            inta_prev_reg <= inta;
            inta_arm_reg  <= inta_arm_reg | ~inta;
            irr_reg       <= irr_next;
            isr_reg       <= isr_next;
            vector_reg    <= vector_next;
            intr_reg      <= |qual;
            if (cs && we && addr == 2'd0) imr_reg  <= din[NUM_IRQ-1:0];
            if (cs && we && addr == 2'd1) base_reg <= {din[7:3], 3'b000};
        end
    end

    always_comb begin
        imr_pad = 8'h00;
        irr_pad = 8'h00;
        isr_pad = 8'h00;
        imr_pad[NUM_IRQ-1:0] = imr_reg;
        irr_pad[NUM_IRQ-1:0] = irr_reg;
        isr_pad[NUM_IRQ-1:0] = isr_reg;
        case (addr)
            2'd0:    dout = imr_pad;
            2'd1:    dout = irr_pad;
            2'd2:    dout = isr_pad;
            default: dout = 8'hFF;
        endcase
    end

    assign intr   = intr_reg;
    assign vector = vector_reg;

endmodule

// File: tb/tb_m72_pic.sv
// Directed bench for m72_pic; acknowledged vectors are checked by a scoreboard monitor on vec_valid rise.
module tb_m72_pic;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs = 1'b0, we = 1'b0, inta = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] irq_in = 8'h00;
    logic [7:0] dout, vector;
    logic       intr, vec_valid;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic       vv_prev = 1'b0;

    m72_pic #(.NUM_IRQ(8), .VEC_BASE_RST(8'h20)) dut (
        .clock(clock), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr), .din(din),
        .dout(dout), .irq_in(irq_in), .intr(intr), .inta(inta),
        .vector(vector), .vec_valid(vec_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    always @(negedge clock) begin
        if (vec_valid && !vv_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL vector_unexpected actual=%h required=none", vector);
            end else begin
                check("vector", vector, exp_q.pop_front());
            end
        end
        vv_prev = vec_valid;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        cs = 1'b1; we = 1'b0; addr = a;
        #1;
        check(name, dout, exp);
        cs = 1'b0;
    endtask

    task automatic chk_intr(input string name, input logic exp);
        check(name, {7'b0, intr}, {7'b0, exp});
    endtask

    // One-cycle source pulse plus one clock, so intr reflects the new request.
    task automatic raise(input int ch);
        irq_in[ch] = 1'b1;
        tick();
        irq_in[ch] = 1'b0;
        tick();
    endtask

    task automatic ack(input logic [7:0] exp);
        exp_q.push_back(exp);
        inta = 1'b1;
        tick();
        tick();
        check("vec_valid_hold", {7'b0, vec_valid}, 8'h01);
        inta = 1'b0;
        tick();
        check("vec_valid_drop", {7'b0, vec_valid}, 8'h00);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_vec_valid", {7'b0, vec_valid}, 8'h00);
        check("rst_vector", vector, 8'h00);
        chk_intr("rst_intr", 1'b0);
        rd_chk("rst_imr", 2'd0, 8'hFF);
        rd_chk("rst_irr", 2'd1, 8'h00);
        rd_chk("rst_isr", 2'd2, 8'h00);
        rd_chk("rd_reserved", 2'd3, 8'hFF);
        reset_n = 1'b1;
        tick();

`ifdef M72_PIC_AUTO_EOI_EN
        wr(2'd0, 8'h00);
        raise(3);
        chk_intr("ae_intr1", 1'b1);
        ack(8'h23);
        rd_chk("ae_isr1", 2'd2, 8'h00);
        chk_intr("ae_intr_clr", 1'b0);
        raise(3);
        chk_intr("ae_intr2", 1'b1);
        ack(8'h23);
        rd_chk("ae_isr2", 2'd2, 8'h00);
        wr(2'd2, 8'h00);
        rd_chk("ae_isr_eoi", 2'd2, 8'h00);
        rd_chk("ae_irr", 2'd1, 8'h00);
`else
        // Single request on channel 3; base write drops the low three bits.
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h27);
        irq_in[3] = 1'b1;
        tick();
        irq_in[3] = 1'b0;
        chk_intr("ch3_intr_early", 1'b0);
        tick();
        chk_intr("ch3_intr", 1'b1);
        rd_chk("ch3_irr", 2'd1, 8'h08);
        ack(8'h23);
        rd_chk("ch3_isr", 2'd2, 8'h08);
        rd_chk("ch3_irr_clr", 2'd1, 8'h00);
        chk_intr("ch3_intr_clr", 1'b0);
        wr(2'd2, 8'h00);
        rd_chk("ch3_isr_eoi", 2'd2, 8'h00);

        // Simultaneous channels 5 and 1.
        irq_in[5] = 1'b1; irq_in[1] = 1'b1;
        tick();
        irq_in = 8'h00;
        tick();
        chk_intr("dual_intr", 1'b1);
        ack(8'h21);
        chk_intr("dual_nested_block", 1'b0);
        rd_chk("dual_isr", 2'd2, 8'h02);
        rd_chk("dual_irr", 2'd1, 8'h20);
        wr(2'd2, 8'h00);
        tick();
        chk_intr("dual_intr2", 1'b1);
        ack(8'h25);
        wr(2'd2, 8'h00);

        // Nesting: ISR[2] blocks ch4, ch0 preempts.
        raise(2);
        ack(8'h22);
        raise(4);
        tick();
        chk_intr("nest_ch4_blocked", 1'b0);
        rd_chk("nest_irr4", 2'd1, 8'h10);
        raise(0);
        chk_intr("nest_ch0_intr", 1'b1);
        ack(8'h20);
        rd_chk("nest_isr05", 2'd2, 8'h05);
        wr(2'd2, 8'h00);
        rd_chk("nest_isr04", 2'd2, 8'h04);
        tick();
        chk_intr("nest_still_blocked", 1'b0);
        wr(2'd2, 8'h00);
        rd_chk("nest_isr00", 2'd2, 8'h00);
        tick();
        chk_intr("nest_ch4_intr", 1'b1);
        ack(8'h24);
        wr(2'd2, 8'h00);

        // Masked request gives a spurious acknowledge and is retained.
        wr(2'd0, 8'hFF);
        raise(2);
        chk_intr("mask_intr", 1'b0);
        ack(8'h27);
        rd_chk("spur_irr", 2'd1, 8'h04);
        rd_chk("spur_isr", 2'd2, 8'h00);
        wr(2'd0, 8'h00);
        tick();
        chk_intr("unmask_intr", 1'b1);
        ack(8'h22);
        wr(2'd2, 8'h00);

        // Channel 6 re-request in the same clock as its acknowledge.
        raise(6);
        chk_intr("ch6_intr", 1'b1);
        exp_q.push_back(8'h26);
        irq_in[6] = 1'b1; inta = 1'b1;
        tick();
        irq_in[6] = 1'b0;
        tick();
        inta = 1'b0;
        tick();
        rd_chk("ch6_irr_kept", 2'd1, 8'h40);
        rd_chk("ch6_isr", 2'd2, 8'h40);
        chk_intr("ch6_blocked", 1'b0);
        wr(2'd2, 8'h00);
        tick();
        chk_intr("ch6_intr2", 1'b1);
        ack(8'h26);
        wr(2'd2, 8'h00);

        // Reset mid-acknowledge with a source and inta held high.
        raise(1);
        exp_q.push_back(8'h21);
        inta = 1'b1; irq_in[0] = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("rsta_vec_valid", {7'b0, vec_valid}, 8'h00);
        check("rsta_vector", vector, 8'h00);
        wr(2'd0, 8'h00);
        tick();
        tick();
        chk_intr("rsta_no_edge_intr", 1'b0);
        rd_chk("rsta_irr", 2'd1, 8'h00);
        check("rsta_no_ack", {7'b0, vec_valid}, 8'h00);
        irq_in[0] = 1'b0; inta = 1'b0;
        tick();
        raise(0);
        chk_intr("rsta_rearm_intr", 1'b1);
        ack(8'h20);
        wr(2'd2, 8'h00);

        // High base with the lowest-priority channel.
        wr(2'd1, 8'hFD);
        raise(7);
        chk_intr("ch7_intr", 1'b1);
        ack(8'hFF);
        wr(2'd2, 8'h00);
`endif

        tick();
        check("sb_empty", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
